rect_plotter: RTL and testbench
===============================

# rect_plotter

Pixel-stream generator between the sprite/motion control FSM and `vga_adapter`. It accepts one filled-rectangle request (origin, size, colour) over a valid/ready handshake and emits one candidate pixel per clock as `plot`/`x_out`/`y_out`/`colour_out`, clipped to the 160x120 frame. Motion logic can place blocks partly off-screen, including above the top edge, and erase or draw them with a single command instead of hand-counting pixels.

## Interface
- `SCREEN_W`, 160: visible width; pixels with x ≥ SCREEN_W are suppressed.
- `SCREEN_H`, 120: visible height; pixels with y < 0 or y ≥ SCREEN_H are suppressed.
- `MAX_DIM`, 32: maximum width and height; sets the 6-bit size fields.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  block idle, request may be accepted
- `req_x`  in  8  left column, unsigned
- `req_y`  in  9  top row, two's-complement signed (−256..255)
- `req_w`  in  6  width in pixels (0..MAX_DIM)
- `req_h`  in  6  height in pixels (0..MAX_DIM)
- `req_colour`  in  3  fill colour
- `plot`  out  1  write strobe to `vga_adapter`
- `x_out`  out  8  pixel column
- `y_out`  out  7  pixel row
- `colour_out`  out  3  pixel colour
- `busy`  out  1  request in flight (state ≠ IDLE)
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SCAN, FIN.
- **IDLE:** `req_ready` = 1. On `req_valid && req_ready` all request fields are latched.
  - If w·h = 0, go to FIN.
  - Otherwise clear col/row and go to SCAN.
- **SCAN:** one slot per cycle, raster order, col fastest.
  - At col = w−1, col wraps to 0 and row increments.
  - At col = w−1 and row = h−1, go to FIN.
- **FIN:** lasts one cycle, then IDLE.
- Request inputs are ignored outside IDLE. `req_valid` held during a scan has no effect on the in-flight rectangle.
- Coordinate arithmetic:
  - px = {1'b0, x0} + col, 9 bits unsigned.
  - py = sext(y0) + row, 10 bits signed.
  - visible = (px < SCREEN_W) && (py ≥ 0) && (py < SCREEN_H).
- Each SCAN slot loads the output register:
  - `plot` ← visible.
  - If visible: `x_out` ← px[7:0], `y_out` ← py[6:0], `colour_out` ← latched colour.
  - If not visible: `x_out`, `y_out`, `colour_out` hold their previous values.
- Clipped slots still consume a cycle. Scan length is always w·h, independent of clipping.
- `done` register ← 1 on the cycle the FSM leaves FIN; 0 otherwise.
- `plot` ← 0 in IDLE and FIN.

## Timing
- Let E0 be the accepting edge and N = w·h.
- Pixel slot k (0..N−1) appears on the outputs in the cycle following edge E0+1+k. There is one cycle of output-register latency after the scan counter.
- `done` is high in the cycle following edge E0+N+1, exactly one cycle long.
- `req_ready` rises in that same cycle. The earliest next accept is edge E0+N+2.
- Zero-size request: no `plot` at all, and `done` is high in the cycle following edge E0+1.
- `busy` is high from E0 until `req_ready` returns.
- Reset values: `plot`=0, `done`=0, `busy`=0, `req_ready`=1 (state IDLE), `x_out`=0, `y_out`=0, `colour_out`=0, col/row=0.
- Reset asserted mid-scan abandons the rectangle. No further `plot` occurs after the reset edge, and `done` is not issued for the abandoned request.
- If `resetn` and `req_valid` are both active at the same edge, reset wins and the request is not accepted.

## Structure
- Shared package holds:
  - SCREEN_W, SCREEN_H.
  - Coordinate widths: X_W=8, Y_W=7, signed origin width 9.
  - Colour width 3 and colour constants: BLACK=3'b000, RED=3'b100, GREEN=3'b010, BLUE=3'b001, WHITE=3'b111.
  - FSM state encoding.
- One sub-module, `rect_scan_counter`, holds the col/row counter with load, advance, and a last-slot flag.
- Clipping compare and output register stay in `rect_plotter`.

## Test plan
- Reset held 3 cycles, then released with `req_valid`=0: `req_ready`=1, `busy`=0, `plot`=0, `done`=0, `x_out`/`y_out`/`colour_out`=0.
- Request x=10, y=20, w=3, h=2, colour=3'b100:
  - Six `plot` cycles in order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), first in cycle after E0+1.
  - `done` and `req_ready` high in cycle after E0+7.
- Top clip, x=5, y=9'h1FE (−2), w=2, h=4:
  - 8 slots, only 4 plots: (5,0), (6,0), (5,1), (6,1).
  - `done` in cycle after E0+9.
- Right/bottom clip, x=158, y=118, w=4, h=4:
  - Plots only (158,118), (159,118), (158,119), (159,119).
  - `done` in cycle after E0+17.
  - Also x=250, w=10: px must not wrap to 0–3, so no plot.
- w=0, h=5: no `plot`; `done` in cycle after E0+1.
- `req_valid` held high across two requests, with fields changed mid-scan: the first rectangle is unaffected, and the second is accepted at edge E0+N+2.
- Reset pulsed during slot 3 of a 4x4: `plot`=0 from the reset edge onward and no `done` pulse.

Source files
------------

// File: rtl/rect_plotter_pkg.sv
// Shared constants, widths, colours and FSM encoding for the rectangle plotter.
// Imported by rect_plotter and rect_scan_counter.
package rect_plotter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int MAX_DIM  = 32;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ORIGIN_W = 9;
  localparam int DIM_W    = 6;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
  localparam logic [COLOUR_W-1:0] BLUE  = 3'b001;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Column/row raster counter for one rectangle; column runs fastest and
// the last-slot flag marks the final (w-1, h-1) position.
module rect_scan_counter
  import rect_plotter_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             advance,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             last
);

  logic col_end;

  assign col_end = (col == (w - 6'd1));
  assign last    = col_end && (row == (h - 6'd1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row + 6'd1;
      end else begin
        col <= col + 6'd1;
      end
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Filled-rectangle pixel stream generator: one candidate pixel per clock,
// clipped to the visible frame, with a registered output stage.
module rect_plotter
  import rect_plotter_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [X_W-1:0]      req_x,
  input  logic [ORIGIN_W-1:0] req_y,
  input  logic [DIM_W-1:0]    req_w,
  input  logic [DIM_W-1:0]    req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                busy,
  output logic                done
);

  state_t              state;
  logic [X_W-1:0]      x0;
  logic [ORIGIN_W-1:0] y0;
  logic [DIM_W-1:0]    w_lat;
  logic [DIM_W-1:0]    h_lat;
  logic [COLOUR_W-1:0] colour_lat;

  logic [DIM_W-1:0]    col;
  logic [DIM_W-1:0]    row;
  logic                last;
  logic                accept;
  logic                scanning;

  logic [8:0]          px;
  logic [9:0]          py;
  logic                visible;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_ready && req_valid;
  assign scanning  = (state == SCAN);

  rect_scan_counter u_counter (
    .clk     (clk),
    .resetn  (resetn),
    .load    (accept),
    .advance (scanning),
    .w       (w_lat),
    .h       (h_lat),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  // px is widened so origins near 255 cannot wrap back onto the left edge;
  // py is sign-extended so rows above the top edge are negative and clipped.
  assign px      = {1'b0, x0} + {3'b000, col};
  assign py      = {y0[ORIGIN_W-1], y0} + {4'b0000, row};
  assign visible = (px < 9'(SCREEN_W)) && !py[9] && (py[8:0] < 9'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      w_lat      <= '0;
      h_lat      <= '0;
      colour_lat <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            x0         <= req_x;
            y0         <= req_y;
            w_lat      <= req_w;
            h_lat      <= req_h;
            colour_lat <= req_colour;
            state      <= ((req_w == '0) || (req_h == '0)) ? FIN : SCAN;
          end
        end
        SCAN: begin
          // Clipped slots still take their cycle but leave the outputs held.
          plot <= visible;
          if (visible) begin
            x_out      <= px[X_W-1:0];
            y_out      <= py[Y_W-1:0];
            colour_out <= colour_lat;
          end
          if (last) begin
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed clipping cases plus random
// rectangles compared slot-by-slot against a raster reference model.
module tb_rect_plotter;
  import rect_plotter_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = '0;
  logic [8:0] req_y = '0;
  logic [5:0] req_w = '0;
  logic [5:0] req_h = '0;
  logic [2:0] req_colour = '0;
  logic       plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       busy;
  logic       done;

  int checkCount = 0;
  int errorCount = 0;
  int lastX = 0;
  int lastY = 0;
  int lastC = 0;
  int nextX, nextY, nextW, nextH, nextC;

  rect_plotter dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .plot       (plot),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference: slot k of a w-wide rectangle sits at (x + k%w, y + k/w).
  function automatic bit slotVisible(input int x, input int y9, input int w, input int k,
                                     output int px, output int py);
    int ys;
    ys = (y9 >= 256) ? y9 - 512 : y9;
    px = x + (k % w);
    py = ys + (k / w);
    return (px < 160) && (py >= 0) && (py < 120);
  endfunction

  task automatic checkSlot(input int x, input int y, input int w, input int c, input int k);
    int px, py;
    bit vis;
    vis = slotVisible(x, y, w, k, px, py);
    if (vis) begin
      lastX = px;
      lastY = py;
      lastC = c;
    end
    checkOutput("plot", plot, vis);
    checkOutput("x_out", x_out, lastX);
    checkOutput("y_out", y_out, lastY);
    checkOutput("colour_out", colour_out, lastC);
    checkOutput("done_scan", done, 0);
    checkOutput("busy_scan", busy, 1);
    checkOutput("ready_scan", req_ready, 0);
  endtask

  task automatic applyStimulus(input int x, input int y, input int w, input int h, input int c,
                               input bit chain, input bit holdNext);
    int n;
    int waited;
    n = w * h;
    waited = 0;
    if (!chain) begin
      while (!req_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("ready_before_req", req_ready, 1);
      req_x = 8'(x);
      req_y = 9'(y);
      req_w = 6'(w);
      req_h = 6'(h);
      req_colour = 3'(c);
      req_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("done_pulse_width", done, 0);
    checkOutput("plot_after_accept", plot, 0);
    if (holdNext) begin
      req_x = 8'(nextX);
      req_y = 9'(nextY);
      req_w = 6'(nextW);
      req_h = 6'(nextH);
      req_colour = 3'(nextC);
    end else begin
      req_valid = 1'b0;
    end
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      checkSlot(x, y, w, c, j - 1);
    end
    @(negedge clk);
    checkOutput("done_end", done, 1);
    checkOutput("ready_end", req_ready, 1);
    checkOutput("busy_end", busy, 0);
    checkOutput("plot_end", plot, 0);
  endtask

  initial begin
    int rx, ry, rw, rh, rc;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_plot", plot, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_x", x_out, 0);
    checkOutput("rst_y", y_out, 0);
    checkOutput("rst_colour", colour_out, 0);

    applyStimulus(10, 20, 3, 2, RED, 0, 0);
    applyStimulus(5, 9'h1FE, 2, 4, WHITE, 0, 0);
    applyStimulus(158, 118, 4, 4, BLUE, 0, 0);
    applyStimulus(250, 50, 10, 1, GREEN, 0, 0);
    applyStimulus(30, 40, 0, 5, RED, 0, 0);

    nextX = 100; nextY = 60; nextW = 2; nextH = 2; nextC = BLUE;
    applyStimulus(20, 10, 3, 3, GREEN, 0, 1);
    applyStimulus(100, 60, 2, 2, BLUE, 1, 0);

    for (int i = 0; i < 25; i++) begin
      rw = $urandom_range(0, 32);
      rh = $urandom_range(0, 32);
      if ($urandom_range(0, 7) == 0) rw = 0;
      rx = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) ry = $urandom_range(0, 511);
      else ry = ($urandom_range(0, 180) - 40) & 511;
      rc = $urandom_range(0, 7);
      applyStimulus(rx, ry, rw, rh, rc, 0, 0);
    end

    // Reset lands on the edge that would show slot 3 of a 4x4.
    @(negedge clk);
    req_x = 8'd40; req_y = 9'd30; req_w = 6'd4; req_h = 6'd4; req_colour = GREEN;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checkSlot(40, 30, 4, GREEN, j - 1);
    end
    resetn = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    lastX = 0; lastY = 0; lastC = 0;
    checkOutput("abort_plot", plot, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_x", x_out, lastX);
    @(negedge clk);
    checkOutput("reset_beats_valid", busy, 0);
    req_valid = 1'b0;
    resetn = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      checkOutput("post_abort_plot", plot, 0);
      checkOutput("post_abort_done", done, 0);
      checkOutput("post_abort_ready", req_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
